// File: rtl/data_cache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache in front of MemoryController.
// Define DCACHE_STATS_EN to add the stat_hits/stat_misses counters.
module data_cache_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LINES  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req_valid,
  input  logic                  cpu_req_write,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
  output logic                  cpu_req_ready,
  output logic                  cpu_resp_valid,
  output logic [DATA_WIDTH-1:0] cpu_resp_rdata,
  input  logic                  flush,
  output logic                  flush_done,
  output logic [31:0]           mem_addr,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [31:0]           mem_write_val,
  input  logic [31:0]           mem_read_val,
  input  logic                  mem_response
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_EVICT, S_REFILL, S_RESP, S_FLUSH
  } state_t;

  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic [NUM_LINES-1:0]  r_valid, r_dirty;
  logic [TAG_W-1:0]      r_tag [NUM_LINES];
  logic [DATA_WIDTH-1:0] r_data [NUM_LINES];
  logic [IDX_W-1:0]      r_fidx;

  logic [IDX_W-1:0]      w_idx, w_vidx;
  logic [TAG_W-1:0]      w_rtag;
  logic                  w_hit, w_fdirty, w_flast;
  logic [ADDR_WIDTH-1:0] w_vaddr, w_maddr;
  logic [DATA_WIDTH-1:0] w_vdata;

  assign w_idx    = r_addr[IDX_W-1:0];
  assign w_rtag   = r_addr[ADDR_WIDTH-1:IDX_W];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_rtag);
  assign w_vidx   = (r_state == S_FLUSH) ? r_fidx : w_idx;
  assign w_vaddr  = {r_tag[w_vidx], w_vidx};
  assign w_vdata  = r_data[w_vidx];
  assign w_fdirty = r_dirty[r_fidx];
  assign w_flast  = (r_fidx == IDX_W'(NUM_LINES - 1));

  assign cpu_resp_rdata = r_rdata;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    flush_done     = 1'b0;
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    w_maddr        = '0;
    unique case (r_state)
      S_IDLE: begin
        if (flush) begin
          w_next = S_FLUSH;
        end else begin
          cpu_req_ready = 1'b1;
          if (cpu_req_valid) w_next = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (w_hit)
          w_next = S_RESP;
        else if (r_valid[w_idx] && r_dirty[w_idx])
          w_next = S_EVICT;
        else
          w_next = S_REFILL;
      end
      S_EVICT: begin
        mem_write_en = 1'b1;
        w_maddr      = w_vaddr;
        if (mem_response) w_next = S_REFILL;
      end
      S_REFILL: begin
        mem_read_en = 1'b1;
        w_maddr     = r_addr;
        if (mem_response) w_next = S_RESP;
      end
      S_RESP: begin
        cpu_resp_valid = 1'b1;
        w_next         = S_IDLE;
      end
      S_FLUSH: begin
        // a written-back line is revisited clean, giving one idle cycle on the bus
        if (w_fdirty) begin
          mem_write_en = 1'b1;
          w_maddr      = w_vaddr;
        end else if (w_flast) begin
          flush_done = 1'b1;
          w_next     = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
    mem_addr      = 32'(w_maddr);
    mem_write_val = mem_write_en ? 32'(w_vdata) : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_valid <= '0;
      r_dirty <= '0;
      r_fidx  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (!flush && cpu_req_valid) begin
            r_addr  <= cpu_req_addr;
            r_write <= cpu_req_write;
            r_wdata <= cpu_req_wdata;
          end
        end
        S_LOOKUP: begin
          if (w_hit && !r_write) r_rdata <= r_data[w_idx];
          if (w_hit && r_write)  r_dirty[w_idx] <= 1'b1;
        end
        S_EVICT: begin
          if (mem_response) r_dirty[w_idx] <= 1'b0;
        end
        S_REFILL: begin
          if (mem_response) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= r_write;
            if (!r_write) r_rdata <= mem_read_val[DATA_WIDTH-1:0];
          end
        end
        S_FLUSH: begin
          if (w_fdirty) begin
            if (mem_response) r_dirty[r_fidx] <= 1'b0;
          end else begin
            r_fidx <= r_fidx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == S_LOOKUP && w_hit && r_write)
        r_data[w_idx] <= r_wdata;
      if (r_state == S_REFILL && mem_response) begin
        r_data[w_idx] <= r_write ? r_wdata : mem_read_val[DATA_WIDTH-1:0];
        r_tag[w_idx]  <= w_rtag;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (r_state == S_LOOKUP) begin
      if (w_hit) stat_hits   <= stat_hits + 32'd1;
      else       stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed bench for data_cache_ctrl with a small MemoryController model.
// Stats checks are built only when DCACHE_STATS_EN is defined.
module tb_data_cache_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req_valid, cpu_req_write;
  logic [7:0]  cpu_req_addr;
  logic [31:0] cpu_req_wdata;
  logic        cpu_req_ready, cpu_resp_valid;
  logic [31:0] cpu_resp_rdata;
  logic        flush, flush_done;
  logic [31:0] mem_addr, mem_write_val;
  logic        mem_read_en, mem_write_en;
  logic [31:0] mem_read_val;
  logic        mem_response;
`ifdef DCACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  data_cache_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_LINES(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_write(cpu_req_write),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_req_ready(cpu_req_ready), .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_rdata(cpu_resp_rdata),
    .flush(flush), .flush_done(flush_done),
    .mem_addr(mem_addr), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .mem_write_val(mem_write_val),
    .mem_read_val(mem_read_val), .mem_response(mem_response)
`ifdef DCACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [256];
  int          cnt = 0;
  int          n_rd = 0, n_wr = 0, ev = 0, rd_ev = 0, wr_ev = 0;
  logic [7:0]  last_rd_addr = '0;
  logic [7:0]  wr_addr_q [$];
  logic [31:0] wr_data_q [$];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
    mem[8'h03] = 32'h11;
    mem[8'h15] = 32'h77;
  end

  initial begin
    mem_response = 1'b0;
    mem_read_val = '0;
  end

  always @(posedge clk) begin
    mem_response <= 1'b0;
    if (reset) begin
      cnt <= 0;
    end else if ((mem_read_en || mem_write_en) && !mem_response) begin
      if (cnt == LAT) begin
        cnt          <= 0;
        mem_response <= 1'b1;
        ev           <= ev + 1;
        if (mem_write_en) begin
          mem[mem_addr[7:0]] <= mem_write_val;
          wr_addr_q.push_back(mem_addr[7:0]);
          wr_data_q.push_back(mem_write_val);
          n_wr  <= n_wr + 1;
          wr_ev <= ev + 1;
        end else begin
          mem_read_val <= mem[mem_addr[7:0]];
          last_rd_addr <= mem_addr[7:0];
          n_rd  <= n_rd + 1;
          rd_ev <= ev + 1;
        end
      end else begin
        cnt <= cnt + 1;
      end
    end
  end

  int resp_cnt = 0, fd_cnt = 0, both_err = 0;
  always @(negedge clk) begin
    if (cpu_resp_valid) resp_cnt++;
    if (flush_done) fd_cnt++;
    if (mem_read_en && mem_write_en) both_err++;
  end

  task automatic cpu_op(input logic w, input logic [7:0] a,
                        input logic [31:0] d,
                        output logic [31:0] rd, output int lat);
    int b;
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_write = w;
    cpu_req_addr  = a;
    cpu_req_wdata = d;
    b = 0;
    while (!cpu_req_ready && b < 50) begin
      @(negedge clk);
      b++;
    end
    @(posedge clk);
    #1 cpu_req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cpu_resp_valid && lat < 100);
    if (!cpu_resp_valid) begin
      total++; bad++;
      $display("FAIL resp_timeout addr=%h got none want pulse", a);
    end
    rd = cpu_resp_rdata;
  endtask

  task automatic do_flush(output int cyc);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!flush_done && cyc < 500);
    if (!flush_done) begin
      total++; bad++;
      $display("FAIL flush_timeout got none want flush_done");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    total++;
    if (cpu_req_ready !== 1'b1) begin
      bad++; $display("FAIL rst_ready got %b want 1", cpu_req_ready);
    end
    total++;
    if ({cpu_resp_valid, flush_done, mem_read_en, mem_write_en} !== 4'b0) begin
      bad++;
      $display("FAIL rst_ctrl got %b want 0000",
               {cpu_resp_valid, flush_done, mem_read_en, mem_write_en});
    end
    total++;
    if ({cpu_resp_rdata, mem_addr, mem_write_val} !== 96'd0) begin
      bad++;
      $display("FAIL rst_data got %h %h %h want 0",
               cpu_resp_rdata, mem_addr, mem_write_val);
    end
  endtask

  task automatic test_cold_read();
    logic [31:0] rd;
    int lat, rd0, wr0;
    rd0 = n_rd; wr0 = n_wr;
    cpu_op(1'b0, 8'h03, 32'h0, rd, lat);
    total++;
    if (rd !== 32'h11) begin
      bad++; $display("FAIL cold_data got %h want 00000011", rd);
    end
    total++;
    if (n_rd !== rd0 + 1 || last_rd_addr !== 8'h03 || n_wr !== wr0) begin
      bad++;
      $display("FAIL cold_mem got rd=%0d a=%h wr=%0d want rd=%0d a=03 wr=%0d",
               n_rd, last_rd_addr, n_wr, rd0 + 1, wr0);
    end
    cpu_op(1'b0, 8'h03, 32'h0, rd, lat);
    total++;
    if (rd !== 32'h11 || lat !== 2) begin
      bad++; $display("FAIL hit_read got %h lat=%0d want 00000011 lat=2", rd, lat);
    end
    total++;
    if (n_rd !== rd0 + 1 || n_wr !== wr0) begin
      bad++; $display("FAIL hit_nomem got rd=%0d wr=%0d want %0d %0d",
                      n_rd, n_wr, rd0 + 1, wr0);
    end
  endtask

  task automatic test_evict();
    logic [31:0] rd;
    int lat, wr0;
    cpu_op(1'b0, 8'h05, 32'h0, rd, lat);
    cpu_op(1'b1, 8'h05, 32'hAA, rd, lat);
    total++;
    if (lat !== 2) begin
      bad++; $display("FAIL write_hit_lat got %0d want 2", lat);
    end
    wr0 = n_wr;
    cpu_op(1'b0, 8'h15, 32'h0, rd, lat);
    total++;
    if (rd !== 32'h77) begin
      bad++; $display("FAIL evict_read got %h want 00000077", rd);
    end
    total++;
    if (n_wr !== wr0 + 1 || wr_addr_q[wr0] !== 8'h05 || wr_data_q[wr0] !== 32'hAA) begin
      bad++; $display("FAIL evict_wb got n=%0d want n=%0d addr 05 data aa", n_wr, wr0 + 1);
    end
    total++;
    if (!(wr_ev < rd_ev) || last_rd_addr !== 8'h15) begin
      bad++; $display("FAIL evict_order got wr_ev=%0d rd_ev=%0d a=%h want wr first a=15",
                      wr_ev, rd_ev, last_rd_addr);
    end
    wr0 = n_wr;
    cpu_op(1'b0, 8'h05, 32'h0, rd, lat);
    total++;
    if (rd !== 32'hAA || n_wr !== wr0) begin
      bad++; $display("FAIL reread_5 got %h wr=%0d want 000000aa wr=%0d", rd, n_wr, wr0);
    end
  endtask

  task automatic test_write_miss();
    logic [31:0] rd;
    int lat, rd0;
    rd0 = n_rd;
    cpu_op(1'b1, 8'h07, 32'h55, rd, lat);
    total++;
    if (n_rd !== rd0 + 1 || last_rd_addr !== 8'h07) begin
      bad++; $display("FAIL wmiss_refill got n=%0d a=%h want n=%0d a=07",
                      n_rd, last_rd_addr, rd0 + 1);
    end
    cpu_op(1'b0, 8'h07, 32'h0, rd, lat);
    total++;
    if (rd !== 32'h55 || lat !== 2) begin
      bad++; $display("FAIL wmiss_read got %h lat=%0d want 00000055 lat=2", rd, lat);
    end
  endtask

  task automatic test_flush();
    logic [31:0] rd;
    int lat, cyc, wr0, fd0;
    wr0 = n_wr;
    do_flush(cyc);
    total++;
    if (n_wr !== wr0 + 1 || wr_addr_q[wr0] !== 8'h07 || wr_data_q[wr0] !== 32'h55) begin
      bad++; $display("FAIL flush_line7 got n=%0d want n=%0d addr 07", n_wr, wr0 + 1);
    end
    cpu_op(1'b1, 8'h01, 32'h1111, rd, lat);
    cpu_op(1'b1, 8'h09, 32'h9999, rd, lat);
    wr0 = n_wr; fd0 = fd_cnt;
    do_flush(cyc);
    repeat (3) @(negedge clk);
    total++;
    if (n_wr !== wr0 + 2) begin
      bad++; $display("FAIL flush_count got %0d want %0d", n_wr - wr0, 2);
    end else begin
      total++;
      if (wr_addr_q[wr0] !== 8'h01 || wr_addr_q[wr0+1] !== 8'h09 ||
          wr_data_q[wr0] !== 32'h1111 || wr_data_q[wr0+1] !== 32'h9999) begin
        bad++; $display("FAIL flush_seq got %h,%h want 01,09",
                        wr_addr_q[wr0], wr_addr_q[wr0+1]);
      end
    end
    total++;
    if (fd_cnt !== fd0 + 1) begin
      bad++; $display("FAIL flush_done_once got %0d want 1", fd_cnt - fd0);
    end
    wr0 = n_wr;
    do_flush(cyc);
    total++;
    if (n_wr !== wr0 || cyc !== 16) begin
      bad++; $display("FAIL reflush got wr=%0d cyc=%0d want wr=0 cyc=16", n_wr - wr0, cyc);
    end
    cpu_op(1'b0, 8'h09, 32'h0, rd, lat);
    total++;
    if (rd !== 32'h9999 || lat !== 2) begin
      bad++; $display("FAIL flush_keep_valid got %h lat=%0d want 00009999 lat=2", rd, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int lat, b, r0, rd0;
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_write = 1'b0;
    cpu_req_addr  = 8'h23;
    @(posedge clk);
    #1 cpu_req_valid = 1'b0;
    b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (!mem_read_en && b < 20);
    total++;
    if (!mem_read_en) begin
      bad++; $display("FAIL mid_refill got read_en=0 want 1");
    end
    r0 = resp_cnt; rd0 = n_rd;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (mem_read_en !== 1'b0 || mem_write_en !== 1'b0) begin
      bad++; $display("FAIL mid_enables got %b%b want 00", mem_read_en, mem_write_en);
    end
    reset = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if (resp_cnt !== r0 || n_rd !== rd0) begin
      bad++; $display("FAIL mid_noresp got resp=%0d rd=%0d want 0 0",
                      resp_cnt - r0, n_rd - rd0);
    end
    cpu_op(1'b0, 8'h23, 32'h0, rd, lat);
    total++;
    if (rd !== 32'hA000_0023 || lat <= 2 || n_rd !== rd0 + 1) begin
      bad++; $display("FAIL mid_remiss got %h lat=%0d want a0000023 miss", rd, lat);
    end
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    logic [31:0] rd;
    int lat;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cpu_op(1'b0, 8'h40, 32'h0, rd, lat);
    cpu_op(1'b0, 8'h41, 32'h0, rd, lat);
    cpu_op(1'b0, 8'h40, 32'h0, rd, lat);
    cpu_op(1'b0, 8'h40, 32'h0, rd, lat);
    cpu_op(1'b1, 8'h41, 32'h5, rd, lat);
    total++;
    if (stat_hits !== 32'd3 || stat_misses !== 32'd2) begin
      bad++; $display("FAIL stats got h=%0d m=%0d want 3 2", stat_hits, stat_misses);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (stat_hits !== 32'd0 || stat_misses !== 32'd0) begin
      bad++; $display("FAIL stats_rst got h=%0d m=%0d want 0 0", stat_hits, stat_misses);
    end
  endtask
`endif

  task automatic test_bus_rules();
    total++;
    if (both_err !== 0) begin
      bad++; $display("FAIL both_enables got %0d cycles want 0", both_err);
    end
  endtask

  initial begin
    reset = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_req_write = 1'b0;
    cpu_req_addr  = '0;
    cpu_req_wdata = '0;
    flush = 1'b0;
    test_reset();
    test_cold_read();
    test_evict();
    test_write_miss();
    test_flush();
    test_reset_mid();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    test_bus_rules();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
